// File: rtl/decode_stage.sv
// decode_stage: instruction queue followed by a registered MIPS-style decoder.
// Fetch pushes 32-bit instructions into a DEPTH-entry circular FIFO. The head
// is decoded combinationally and captured in an output register that uses a
// valid/ready handshake.
// Optional feature macro: DECODE_ILLEGAL_EN adds an 'illegal' output. When it
// is set, unrecognised encodings are turned into harmless no-ops.
module decode_stage #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      in_instr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             data_mem_wren,
    output logic             reg_file_wren,
    output logic             reg_file_dmux_sel,
    output logic             reg_file_rmux_sel,
    output logic             alu_mux_sel,
    output logic [3:0]       alu_op,
    output logic [2:0]       pc_control,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [4:0]       shamt,
    output logic [31:0]      imm_ext,
    output logic [25:0]      jaddr,
`ifdef DECODE_ILLEGAL_EN
    output logic             illegal,
`endif
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             load;

    logic [31:0] head;
    logic [5:0]  op;
    logic [5:0]  funct;

    logic        d_dmem;
    logic        d_wren;
    logic        d_dmux;
    logic        d_rmux;
    logic        d_amux;
    logic [3:0]  d_alu;
    logic [2:0]  d_pc;
    logic [4:0]  d_rs;
    logic [4:0]  d_rt;
    logic [4:0]  d_rd;
    logic [4:0]  d_shamt;
    logic [31:0] d_imm;
    logic [25:0] d_jaddr;

    // in_ready depends only on registered occupancy, so it is glitch-free
    // and never forms a loop with in_valid.
    assign in_ready = (count != CNT_W'(DEPTH));
    assign push     = in_valid && in_ready;
    assign load     = (count != '0) && (!out_valid || out_ready);

    assign head  = mem[rd_ptr];
    assign op    = head[31:26];
    assign funct = head[5:0];

`ifdef DECODE_ILLEGAL_EN
    logic d_known;

    // Flags whether the head holds an opcode/funct combination we support.
    always_comb begin
        d_known = 1'b0;
        case (op)
            6'h00: begin
                case (funct)
                    6'h00, 6'h02, 6'h03, 6'h08, 6'h09,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                    6'h25, 6'h26, 6'h27, 6'h2A: d_known = 1'b1;
                    default:                    d_known = 1'b0;
                endcase
            end
            6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D,
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
            6'h2A, 6'h2B: d_known = 1'b1;
            default:      d_known = 1'b0;
        endcase
    end
`endif

    // Decodes the queue head into unit controls and register/immediate fields.
    always_comb begin
        d_rs    = head[25:21];
        d_rt    = head[20:16];
        d_rd    = 5'd0;
        d_shamt = head[10:6];
        d_imm   = {{16{head[15]}}, head[15:0]};
        d_jaddr = 26'd0;
        d_alu   = 4'b1111;
        d_pc    = 3'b000;
        d_dmem  = 1'b0;
        d_wren  = 1'b1;
        d_dmux  = 1'b1;
        d_rmux  = 1'b0;
        d_amux  = 1'b0;
        case (op)
            6'h00: begin
                d_rd   = head[15:11];
                d_imm  = 32'd0;
                d_rmux = 1'b1;
                d_amux = 1'b1;
                case (funct)
                    6'h00: d_alu = 4'b1000;
                    6'h02: d_alu = 4'b1001;
                    6'h03: d_alu = 4'b1010;
                    6'h08, 6'h09: begin
                        d_pc   = 3'b010;
                        d_wren = 1'b0;
                    end
                    6'h20: d_alu = 4'b1011;
                    6'h21: d_alu = 4'b0010;
                    6'h22: d_alu = 4'b1110;
                    6'h23: d_alu = 4'b0110;
                    6'h24: d_alu = 4'b0000;
                    6'h25: d_alu = 4'b0001;
                    6'h26: d_alu = 4'b0011;
                    6'h27: d_alu = 4'b0100;
                    6'h2A: d_alu = 4'b0111;
                    default: d_alu = 4'b1111;
                endcase
            end
            6'h02, 6'h03: begin
                d_rs    = 5'd0;
                d_rt    = 5'd0;
                d_shamt = 5'd0;
                d_imm   = 32'd0;
                d_jaddr = head[25:0];
                d_pc    = 3'b001;
                d_wren  = 1'b0;
                d_amux  = 1'b1;
            end
            6'h04: begin
                d_alu  = 4'b1110;
                d_pc   = 3'b011;
                d_wren = 1'b0;
            end
            6'h05: begin
                d_alu  = 4'b1110;
                d_pc   = 3'b100;
                d_wren = 1'b0;
            end
            6'h08: d_alu = 4'b1011;
            6'h09: d_alu = 4'b0010;
            6'h0A: d_alu = 4'b0111;
            6'h0C: begin
                d_alu = 4'b0000;
                d_imm = {16'd0, head[15:0]};
            end
            6'h0D: begin
                d_alu = 4'b0001;
                d_imm = {16'd0, head[15:0]};
            end
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26: begin
                d_alu  = 4'b1011;
                d_dmux = 1'b0;
            end
            6'h2A, 6'h2B: begin
                d_alu  = 4'b1011;
                d_dmem = 1'b1;
                d_wren = 1'b0;
            end
            default: d_alu = 4'b1111;
        endcase
`ifdef DECODE_ILLEGAL_EN
        if (!d_known) begin
            d_wren = 1'b0;
            d_dmem = 1'b0;
            d_pc   = 3'b000;
            d_alu  = 4'b1111;
        end
`endif
    end

    // Queue storage; no reset needed because count/pointers gate every read.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push) begin
            mem[wr_ptr] <= in_instr;
        end
    end

    // Pointers, occupancy and the decoded output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            out_valid         <= 1'b0;
            data_mem_wren     <= 1'b0;
            reg_file_wren     <= 1'b0;
            reg_file_dmux_sel <= 1'b0;
            reg_file_rmux_sel <= 1'b0;
            alu_mux_sel       <= 1'b0;
            alu_op            <= '0;
            pc_control        <= '0;
            rs                <= '0;
            rt                <= '0;
            rd                <= '0;
            shamt             <= '0;
            imm_ext           <= '0;
            jaddr             <= '0;
`ifdef DECODE_ILLEGAL_EN
            illegal           <= 1'b0;
`endif
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (load) begin
                rd_ptr            <= rd_ptr + PTR_W'(1);
                out_valid         <= 1'b1;
                data_mem_wren     <= d_dmem;
                reg_file_wren     <= d_wren;
                reg_file_dmux_sel <= d_dmux;
                reg_file_rmux_sel <= d_rmux;
                alu_mux_sel       <= d_amux;
                alu_op            <= d_alu;
                pc_control        <= d_pc;
                rs                <= d_rs;
                rt                <= d_rt;
                rd                <= d_rd;
                shamt             <= d_shamt;
                imm_ext           <= d_imm;
                jaddr             <= d_jaddr;
`ifdef DECODE_ILLEGAL_EN
                illegal           <= !d_known;
`endif
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case ({push, load})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage. Accepted instructions
// push a hand-computed expected bundle; a negedge monitor pops and compares
// whenever the DUT completes an output handshake.
module tb_decode_stage;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    typedef struct packed {
        logic        dmem;
        logic        wren;
        logic        dmux;
        logic        rmux;
        logic        amux;
        logic [3:0]  alu;
        logic [2:0]  pc;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [31:0] imm;
        logic [25:0] jaddr;
        logic        ill;
    } bundle_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [31:0]      in_instr = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             flush = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             data_mem_wren;
    logic             reg_file_wren;
    logic             reg_file_dmux_sel;
    logic             reg_file_rmux_sel;
    logic             alu_mux_sel;
    logic [3:0]       alu_op;
    logic [2:0]       pc_control;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       rd;
    logic [4:0]       shamt;
    logic [31:0]      imm_ext;
    logic [25:0]      jaddr;
    logic [CNT_W-1:0] count;
    logic             ill_bit;

    int      checks = 0;
    int      fails  = 0;
    int      cycle  = 0;
    int      out_n  = 0;
    bundle_t cur_exp;
    bundle_t act;
    bundle_t exp_q[$];

    decode_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .in_instr          (in_instr),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .flush             (flush),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .data_mem_wren     (data_mem_wren),
        .reg_file_wren     (reg_file_wren),
        .reg_file_dmux_sel (reg_file_dmux_sel),
        .reg_file_rmux_sel (reg_file_rmux_sel),
        .alu_mux_sel       (alu_mux_sel),
        .alu_op            (alu_op),
        .pc_control        (pc_control),
        .rs                (rs),
        .rt                (rt),
        .rd                (rd),
        .shamt             (shamt),
        .imm_ext           (imm_ext),
        .jaddr             (jaddr),
`ifdef DECODE_ILLEGAL_EN
        .illegal           (ill_bit),
`endif
        .count             (count)
    );

`ifndef DECODE_ILLEGAL_EN
    assign ill_bit = 1'b0;
`endif

    assign act = {data_mem_wren, reg_file_wren, reg_file_dmux_sel, reg_file_rmux_sel,
                  alu_mux_sel, alu_op, pc_control, rs, rt, rd, shamt, imm_ext, jaddr, ill_bit};

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter for throughput measurement.
    always @(posedge clk) cycle <= cycle + 1;

    // Records the expected bundle for every instruction the DUT accepts.
    always @(posedge clk) begin
        if (rst || flush) begin
            exp_q.delete();
        end else if (in_valid && in_ready) begin
            exp_q.push_back(cur_exp);
        end
    end

    // Compares each bundle the DUT hands over against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && !flush && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("[TB] FAIL unexpected_output #%0d: got %h required none", out_n, act);
            end else begin
                bundle_t e;
                e = exp_q.pop_front();
                if (act !== e) begin
                    fails++;
                    $display("[TB] FAIL bundle #%0d: got %h required %h", out_n, act, e);
                end
            end
            out_n++;
        end
    end

    // Hard stop in case something upstream wedges.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic bundle_t make_exp(input logic dm, input logic wr, input logic dx,
                                         input logic rx, input logic ax, input logic [3:0] al,
                                         input logic [2:0] pcc, input logic [4:0] s,
                                         input logic [4:0] t, input logic [4:0] d,
                                         input logic [4:0] sh, input logic [31:0] im,
                                         input logic [25:0] ja, input logic il);
        bundle_t b;
        b = {dm, wr, dx, rx, ax, al, pcc, s, t, d, sh, im, ja, il};
        return b;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] req);
        checks++;
        if (got !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    // Presents one instruction and holds it until accepted (bounded).
    task automatic applyStimulus(input logic [31:0] instr, input bundle_t e);
        logic accepted;
        accepted = 1'b0;
        in_instr = instr;
        cur_exp  = e;
        in_valid = 1'b1;
        for (int t = 0; t < 50 && !accepted; t++) begin
            accepted = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!accepted) begin
            checks++;
            fails++;
            $display("[TB] FAIL accept_timeout: instr %h not accepted", instr);
        end
    endtask

    task automatic waitDrain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 60) begin
            @(posedge clk);
            #1;
            t++;
        end
        checkOutput("drain", {127'd0, (exp_q.size() != 0 || out_valid)}, 128'd0);
    endtask

    bundle_t e_add, e_lw, e_ori, e_beq, e_jal, e_sw, e_subu, e_sra, e_jr, e_ill;
    bundle_t e_andi, e_j, e_addi;
    logic [31:0] instrs[12];
    bundle_t     exps[12];

    initial begin
        int t0;
        e_add  = make_exp(0,1,1,1,1,4'b1011,3'b000,5'd4,5'd5,5'd2,5'd0,32'h0,26'h0,0);
        e_lw   = make_exp(0,1,0,0,0,4'b1011,3'b000,5'd2,5'd4,5'd0,5'd31,32'hFFFFFFFC,26'h0,0);
        e_ori  = make_exp(0,1,1,0,0,4'b0001,3'b000,5'd2,5'd4,5'd0,5'd31,32'h0000FFFC,26'h0,0);
        e_beq  = make_exp(0,0,1,0,0,4'b1110,3'b011,5'd4,5'd5,5'd0,5'd0,32'h3,26'h0,0);
        e_jal  = make_exp(0,0,1,0,1,4'b1111,3'b001,5'd0,5'd0,5'd0,5'd0,32'h0,26'h10,0);
        e_sw   = make_exp(1,0,1,0,0,4'b1011,3'b000,5'd4,5'd5,5'd0,5'd0,32'h8,26'h0,0);
        e_subu = make_exp(0,1,1,1,1,4'b0110,3'b000,5'd5,5'd4,5'd3,5'd0,32'h0,26'h0,0);
        e_sra  = make_exp(0,1,1,1,1,4'b1010,3'b000,5'd0,5'd3,5'd2,5'd2,32'h0,26'h0,0);
        e_jr   = make_exp(0,0,1,1,1,4'b1111,3'b010,5'd31,5'd0,5'd0,5'd0,32'h0,26'h0,0);
`ifdef DECODE_ILLEGAL_EN
        e_ill  = make_exp(0,0,1,0,0,4'b1111,3'b000,5'd0,5'd0,5'd0,5'd0,32'h0,26'h0,1);
`else
        e_ill  = make_exp(0,1,1,0,0,4'b1111,3'b000,5'd0,5'd0,5'd0,5'd0,32'h0,26'h0,0);
`endif
        e_andi = make_exp(0,1,1,0,0,4'b0000,3'b000,5'd4,5'd5,5'd0,5'd31,32'h0000FFFF,26'h0,0);
        e_j    = make_exp(0,0,1,0,1,4'b1111,3'b001,5'd0,5'd0,5'd0,5'd0,32'h0,26'h123,0);
        e_addi = make_exp(0,1,1,0,0,4'b1011,3'b000,5'd4,5'd5,5'd0,5'd31,32'hFFFFFFFF,26'h0,0);

        instrs = '{32'h8C44FFFC, 32'h3444FFFC, 32'h10850003, 32'h0C000010,
                   32'hAC850008, 32'h00A41823, 32'h00031083, 32'h03E00008,
                   32'h3085FFFF, 32'h08000123, 32'h2085FFFF, 32'hFC000000};
        exps   = '{e_lw, e_ori, e_beq, e_jal, e_sw, e_subu, e_sra, e_jr,
                   e_andi, e_j, e_addi, e_ill};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_count", {125'd0, count}, 128'd0);
        checkOutput("reset_out_valid", {127'd0, out_valid}, 128'd0);
        checkOutput("reset_bundle", {37'd0, act}, 128'd0);
        rst = 1'b0;
        checkOutput("reset_in_ready", {127'd0, in_ready}, 128'd1);

        // Minimum latency with an ADD.
        out_ready = 1'b1;
        applyStimulus(32'h00851020, e_add);
        checkOutput("lat_edge1_valid", {127'd0, out_valid}, 128'd0);
        checkOutput("lat_edge1_count", {125'd0, count}, 128'd1);
        @(posedge clk);
        #1;
        checkOutput("lat_edge2_valid", {127'd0, out_valid}, 128'd1);
        waitDrain();

        // Back-to-back stream at full throughput.
        t0 = cycle;
        for (int i = 0; i < 12; i++) applyStimulus(instrs[i], exps[i]);
        checkOutput("throughput_cycles", 128'(cycle - t0), 128'd12);
        waitDrain();

        // Fill to capacity with the consumer stalled.
        out_ready = 1'b0;
        applyStimulus(32'h00851020, e_add);
        applyStimulus(32'h00A41823, e_subu);
        applyStimulus(32'h00031083, e_sra);
        applyStimulus(32'h3085FFFF, e_andi);
        applyStimulus(32'h08000123, e_j);
        checkOutput("full_count", {125'd0, count}, 128'(DEPTH));
        checkOutput("full_in_ready", {127'd0, in_ready}, 128'd0);
        in_instr = 32'h2085FFFF;
        cur_exp  = e_addi;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("full_hold_count", {125'd0, count}, 128'(DEPTH));
        checkOutput("full_hold_in_ready", {127'd0, in_ready}, 128'd0);
        out_ready = 1'b1;
        waitDrain();

        // Flush with a half-full queue and a concurrent push.
        out_ready = 1'b0;
        applyStimulus(32'h8C44FFFC, e_lw);
        applyStimulus(32'h3444FFFC, e_ori);
        applyStimulus(32'h10850003, e_beq);
        checkOutput("pre_flush_count", {125'd0, count}, 128'd2);
        in_instr = 32'h0C000010;
        cur_exp  = e_jal;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        checkOutput("flush_count", {125'd0, count}, 128'd0);
        checkOutput("flush_out_valid", {127'd0, out_valid}, 128'd0);
        checkOutput("flush_in_ready", {127'd0, in_ready}, 128'd1);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("post_flush_valid", {127'd0, out_valid}, 128'd0);
        checkOutput("post_flush_count", {125'd0, count}, 128'd0);

        // Reset in the middle of a stalled stream.
        out_ready = 1'b0;
        applyStimulus(32'h03E00008, e_jr);
        applyStimulus(32'hAC850008, e_sw);
        applyStimulus(32'h00A41823, e_subu);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("midrst_count", {125'd0, count}, 128'd0);
        checkOutput("midrst_out_valid", {127'd0, out_valid}, 128'd0);
        checkOutput("midrst_bundle", {37'd0, act}, 128'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post_rst_in_ready", {127'd0, in_ready}, 128'd1);
        out_ready = 1'b1;
        applyStimulus(32'hFC000000, e_ill);
        waitDrain();

        checkOutput("scoreboard_empty", 128'(exp_q.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
